// File: rtl/dumpoff_sched_pkg.sv
// Shared types and default sizing for the dump-off switch sequencer.
package dumpoff_sched_pkg;

  localparam int DLY_W_DEF   = 16;
  localparam int CNT_W_DEF   = 10;
  localparam int TMO_CYC_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    FIRE,
    ACTIVE,
    DONE
  } state_e;

endpackage

// File: rtl/dumpoff_sched_timer.sv
// Loadable down-counter with a zero flag; used for both the post-RF delay
// and the ACTIVE-window timeout.
module dumpoff_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dumpoff_scheduler.sv
// Dump-off switch sequencer: per echo, waits for rf_end, delays, fires
// state_start, then supervises the returned dumpoff window.
// Optional: define DUMPOFF_SCHED_SYNC_EN to pass rf_end/dumpoff through
// 2-flop synchronizers (rf_end edge-detected); adds 2 cycles of latency.
module dumpoff_scheduler
  import dumpoff_sched_pkg::*;
#(
  parameter int DLY_W   = DLY_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             enable,
  input  logic             scan_start,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_num,
  input  logic             rf_end,
  input  logic             dumpoff,
  output logic             state_start,
  output logic             busy,
  output logic [CNT_W-1:0] echo_idx,
  output logic             scan_done,
  output logic             err_overrun,
  output logic             err_timeout
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_e           state, state_n;
  logic [DLY_W-1:0] cfg_delay_q;
  logic [CNT_W-1:0] cfg_num_q;
  logic             seen_high;
  logic             rf_ev;
  logic             dmp;
  logic             dly_load, dly_dec, dly_zero;
  logic             tmo_load, tmo_dec, tmo_zero;
  logic             latch_cfg, complete, timeout_hit, ovr_set;
  logic [CNT_W:0]   idx_inc;
  logic             last_echo;

`ifdef DUMPOFF_SCHED_SYNC_EN
  logic rf_sync_p0, rf_sync_p1, rf_sync_p2;
  logic dmp_sync_p0, dmp_sync_p1;

  // Sync stage: two flops per input, plus one extra rf flop for edge detect
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rf_sync_p0  <= 1'b0;
      rf_sync_p1  <= 1'b0;
      rf_sync_p2  <= 1'b0;
      dmp_sync_p0 <= 1'b0;
      dmp_sync_p1 <= 1'b0;
    end else begin
      rf_sync_p0  <= rf_end;
      rf_sync_p1  <= rf_sync_p0;
      rf_sync_p2  <= rf_sync_p1;
      dmp_sync_p0 <= dumpoff;
      dmp_sync_p1 <= dmp_sync_p0;
    end
  end

  assign rf_ev = rf_sync_p1 & ~rf_sync_p2;
  assign dmp   = dmp_sync_p1;
`else
  assign rf_ev = rf_end;
  assign dmp   = dumpoff;
`endif

  dumpoff_sched_timer #(.W(DLY_W)) u_dly_timer (
    .clk      (clk_sys),
    .rst      (rst),
    .load     (dly_load),
    .load_val (cfg_delay_q),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  dumpoff_sched_timer #(.W(TMO_W)) u_tmo_timer (
    .clk      (clk_sys),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (TMO_W'(TMO_CYC)),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  assign idx_inc   = {1'b0, echo_idx} + {{CNT_W{1'b0}}, 1'b1};
  assign last_echo = (idx_inc == {1'b0, cfg_num_q});

  always_comb begin
    state_n     = state;
    latch_cfg   = 1'b0;
    dly_load    = 1'b0;
    dly_dec     = 1'b0;
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    ovr_set     = 1'b0;

    // Dropping enable aborts silently: no flag updates, no done pulse
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (scan_start) begin
            latch_cfg = 1'b1;
            state_n   = ARMED;
          end
        end
        ARMED: begin
          if (cfg_num_q == '0) begin
            state_n = DONE;
          end else if (rf_ev) begin
            dly_load = 1'b1;
            state_n  = DELAY;
          end
        end
        DELAY: begin
          ovr_set = rf_ev;
          if (dly_zero) begin
            state_n = FIRE;
          end else begin
            dly_dec = 1'b1;
          end
        end
        FIRE: begin
          ovr_set  = rf_ev;
          tmo_load = 1'b1;
          state_n  = ACTIVE;
        end
        ACTIVE: begin
          ovr_set = rf_ev;
          tmo_dec = 1'b1;
          // A real falling edge wins over a timeout landing in the same cycle
          if (seen_high && !dmp) begin
            complete = 1'b1;
          end else if (tmo_zero) begin
            complete    = 1'b1;
            timeout_hit = 1'b1;
          end
          if (complete) begin
            state_n = last_echo ? DONE : ARMED;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_delay_q <= '0;
      cfg_num_q   <= '0;
      echo_idx    <= '0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      seen_high   <= 1'b0;
    end else begin
      state     <= state_n;
      seen_high <= (state == ACTIVE) && enable && (seen_high || dmp);
      if (latch_cfg) begin
        cfg_delay_q <= cfg_delay;
        cfg_num_q   <= cfg_num;
        echo_idx    <= '0;
        err_overrun <= 1'b0;
        err_timeout <= 1'b0;
      end else begin
        if (complete && (echo_idx < cfg_num_q)) begin
          echo_idx <= idx_inc[CNT_W-1:0];
        end
        if (ovr_set) begin
          err_overrun <= 1'b1;
        end
        if (timeout_hit) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

  assign state_start = (state == FIRE) && enable;
  assign scan_done   = (state == DONE) && enable;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dumpoff_scheduler.sv
// Self-checking bench for dumpoff_scheduler: timing of each trigger is
// predicted from rf_end edge + 1 + delay (+2 when synchronizers are built in).
module tb_dumpoff_scheduler;

  localparam int DLY_W = 16;
  localparam int CNT_W = 10;
  localparam int TMO   = 64;
`ifdef DUMPOFF_SCHED_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic             clk_sys = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic             scan_start = 1'b0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic [CNT_W-1:0] cfg_num = '0;
  logic             rf_end = 1'b0;
  logic             dumpoff = 1'b0;
  logic             state_start, busy, scan_done, err_overrun, err_timeout;
  logic [CNT_W-1:0] echo_idx;

  int cyc = 0;
  int trig_cnt = 0;
  int done_cnt = 0;
  int checks = 0;
  int passes = 0;

  dumpoff_scheduler #(.DLY_W(DLY_W), .CNT_W(CNT_W), .TMO_CYC(TMO)) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .enable      (enable),
    .scan_start  (scan_start),
    .cfg_delay   (cfg_delay),
    .cfg_num     (cfg_num),
    .rf_end      (rf_end),
    .dumpoff     (dumpoff),
    .state_start (state_start),
    .busy        (busy),
    .echo_idx    (echo_idx),
    .scan_done   (scan_done),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) begin
    if (state_start === 1'b1) trig_cnt++;
    if (scan_done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_scan(input int d, input int n, output int c);
    cfg_delay  = d[DLY_W-1:0];
    cfg_num    = n[CNT_W-1:0];
    scan_start = 1'b1;
    c = cyc;
    step();
    scan_start = 1'b0;
  endtask

  task automatic send_rf(output int e);
    rf_end = 1'b1;
    e = cyc + 1;
    step();
    rf_end = 1'b0;
  endtask

  task automatic wait_trig(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_sys);
      if (state_start === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Called at the FIRE-cycle negedge; returns after completion has settled
  task automatic finish_echo(input int hi);
    step();
    dumpoff = 1'b1;
    steps(hi);
    dumpoff = 1'b0;
    steps(3 + SYNC);
  endtask

  task automatic test_reset();
    steps(2);
    checks++;
    if ({state_start, busy, scan_done, err_overrun, err_timeout} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {state_start, busy, scan_done, err_overrun, err_timeout});
    else passes++;
    checks++;
    if (echo_idx !== '0) $display("FAIL reset_idx: got %0d want 0", echo_idx);
    else passes++;
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset busy: got %b want 0", busy);
    else passes++;
  endtask

  task automatic test_basic();
    int c, e, t, d0;
    start_scan(5, 3, c);
    d0 = done_cnt;
    checks++;
    if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy);
    else passes++;
    for (int k = 1; k <= 3; k++) begin
      send_rf(e);
      wait_trig(60, t);
      checks++;
      if (t !== e + 6 + SYNC) $display("FAIL basic_trig%0d: got %0d want %0d", k, t, e + 6 + SYNC);
      else passes++;
      finish_echo(10);
      checks++;
      if (echo_idx !== CNT_W'(k)) $display("FAIL basic_idx%0d: got %0d want %0d", k, echo_idx, k);
      else passes++;
      if (k == 1) begin
        start_scan(1, 1, c);
        checks++;
        if ({busy, echo_idx} !== {1'b1, CNT_W'(1)})
          $display("FAIL start_while_busy: got busy=%b idx=%0d want busy=1 idx=1", busy, echo_idx);
        else passes++;
      end
      if (k < 3) begin
        checks++;
        if (done_cnt - d0 !== 0) $display("FAIL basic_early_done%0d: got %0d want 0", k, done_cnt - d0);
        else passes++;
      end
      while (cyc < e + 39) step();
    end
    checks++;
    if (done_cnt - d0 !== 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy);
    else passes++;
  endtask

  task automatic test_zero();
    int c, e, t, t0, d0;
    t0 = trig_cnt;
    start_scan(7, 0, c);
    t = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      if (scan_done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    checks++;
    if (t !== c + 2) $display("FAIL zero_num_done: got %0d want %0d", t, c + 2);
    else passes++;
    step();
    checks++;
    if ({busy, 1'(trig_cnt != t0)} !== 2'b00)
      $display("FAIL zero_num_idle: got busy=%b trig=%0d want busy=0 trig=0", busy, trig_cnt - t0);
    else passes++;
    start_scan(0, 1, c);
    d0 = done_cnt;
    send_rf(e);
    wait_trig(20, t);
    checks++;
    if (t !== e + 1 + SYNC) $display("FAIL zero_delay_trig: got %0d want %0d", t, e + 1 + SYNC);
    else passes++;
    finish_echo(3);
    checks++;
    if ({echo_idx, 1'(done_cnt - d0 == 1)} !== {CNT_W'(1), 1'b1})
      $display("FAIL zero_delay_end: got idx=%0d done=%0d want idx=1 done=1", echo_idx, done_cnt - d0);
    else passes++;
  endtask

  task automatic test_overrun();
    int c, e, e2, t, t0;
    start_scan(6, 1, c);
    t0 = trig_cnt;
    send_rf(e);
    step();
    send_rf(e2);
    wait_trig(40, t);
    checks++;
    if (t !== e + 7 + SYNC) $display("FAIL overrun_trig: got %0d want %0d", t, e + 7 + SYNC);
    else passes++;
    checks++;
    if (err_overrun !== 1'b1) $display("FAIL overrun_flag: got %b want 1", err_overrun);
    else passes++;
    finish_echo(4);
    checks++;
    if (trig_cnt - t0 !== 1) $display("FAIL overrun_trig_count: got %0d want 1", trig_cnt - t0);
    else passes++;
    checks++;
    if ({busy, err_overrun} !== 2'b01)
      $display("FAIL overrun_sticky: got busy=%b ovr=%b want busy=0 ovr=1", busy, err_overrun);
    else passes++;
    start_scan(2, 1, c);
    checks++;
    if (err_overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", err_overrun);
    else passes++;
    send_rf(e);
    wait_trig(20, t);
    finish_echo(2);
    t0 = trig_cnt;
    send_rf(e);
    steps(3 + SYNC);
    checks++;
    if ({busy, err_overrun, 1'(trig_cnt != t0)} !== 3'b000)
      $display("FAIL rf_in_idle: got busy=%b ovr=%b trig=%0d want 0 0 0", busy, err_overrun, trig_cnt - t0);
    else passes++;
  endtask

  task automatic test_timeout();
    int c, e, t, tt, d0;
    start_scan(3, 2, c);
    d0 = done_cnt;
    send_rf(e);
    wait_trig(30, t);
    tt = -1;
    for (int i = 0; i < TMO + 10; i++) begin
      @(negedge clk_sys);
      if (err_timeout === 1'b1) begin
        tt = cyc;
        break;
      end
    end
    checks++;
    if (tt < t + TMO || tt > t + TMO + 2)
      $display("FAIL timeout_time: got %0d want %0d..%0d", tt, t + TMO, t + TMO + 2);
    else passes++;
    checks++;
    if (echo_idx !== CNT_W'(1)) $display("FAIL timeout_idx: got %0d want 1", echo_idx);
    else passes++;
    steps(2);
    checks++;
    if (busy !== 1'b1) $display("FAIL timeout_continue: got busy=%b want 1", busy);
    else passes++;
    send_rf(e);
    wait_trig(30, t);
    checks++;
    if (t !== e + 4 + SYNC) $display("FAIL timeout_next_trig: got %0d want %0d", t, e + 4 + SYNC);
    else passes++;
    finish_echo(5);
    checks++;
    if ({echo_idx, err_timeout, 1'(done_cnt - d0 == 1)} !== {CNT_W'(2), 1'b1, 1'b1})
      $display("FAIL timeout_end: got idx=%0d tmo=%b done=%0d want idx=2 tmo=1 done=1",
               echo_idx, err_timeout, done_cnt - d0);
    else passes++;
  endtask

  task automatic test_abort();
    int c, e, t, f, t0, d0;
    start_scan(4, 2, c);
    send_rf(e);
    f = e + 5 + SYNC;
    while (cyc < f) step();
    enable = 1'b0;
    t0 = trig_cnt;
    d0 = done_cnt;
    @(negedge clk_sys);
    checks++;
    if (state_start !== 1'b0) $display("FAIL abort_gate: got %b want 0", state_start);
    else passes++;
    step();
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy);
    else passes++;
    steps(3);
    checks++;
    if ((trig_cnt - t0) + (done_cnt - d0) !== 0)
      $display("FAIL abort_quiet: got trig=%0d done=%0d want 0 0", trig_cnt - t0, done_cnt - d0);
    else passes++;
    enable = 1'b1;
    step();
    start_scan(2, 1, c);
    send_rf(e);
    wait_trig(20, t);
    checks++;
    if (t !== e + 3 + SYNC) $display("FAIL abort_restart_trig: got %0d want %0d", t, e + 3 + SYNC);
    else passes++;
    finish_echo(6);
    checks++;
    if ({echo_idx, 1'(done_cnt - d0 == 1), busy} !== {CNT_W'(1), 1'b1, 1'b0})
      $display("FAIL abort_restart_end: got idx=%0d done=%0d busy=%b want 1 1 0",
               echo_idx, done_cnt - d0, busy);
    else passes++;
  endtask

  task automatic test_random();
    int c, e, t, d, n, d0;
    for (int s = 0; s < 5; s++) begin
      d = int'($urandom_range(0, 8));
      n = int'($urandom_range(1, 4));
      start_scan(d, n, c);
      d0 = done_cnt;
      for (int k = 1; k <= n; k++) begin
        steps(int'($urandom_range(0, 4)));
        send_rf(e);
        wait_trig(d + 20, t);
        checks++;
        if (t !== e + 1 + d + SYNC)
          $display("FAIL rand_trig s%0d e%0d: got %0d want %0d", s, k, t, e + 1 + d + SYNC);
        else passes++;
        finish_echo(int'($urandom_range(1, 12)));
        checks++;
        if (echo_idx !== CNT_W'(k)) $display("FAIL rand_idx s%0d e%0d: got %0d want %0d", s, k, echo_idx, k);
        else passes++;
      end
      checks++;
      if ({1'(done_cnt - d0 == 1), busy, err_overrun, err_timeout} !== 4'b1000)
        $display("FAIL rand_end s%0d: got done=%0d busy=%b ovr=%b tmo=%b want 1 0 0 0",
                 s, done_cnt - d0, busy, err_overrun, err_timeout);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    int c, e, e2, t;
    start_scan(3, 3, c);
    send_rf(e);
    wait_trig(20, t);
    finish_echo(4);
    send_rf(e);
    step();
    send_rf(e2);
    wait_trig(20, t);
    step();
    dumpoff = 1'b1;
    steps(2);
    @(negedge clk_sys);
    checks++;
    if ({busy, echo_idx, err_overrun} !== {1'b1, CNT_W'(1), 1'b1})
      $display("FAIL pre_reset_state: got busy=%b idx=%0d ovr=%b want 1 1 1", busy, echo_idx, err_overrun);
    else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({state_start, busy, scan_done, err_overrun, err_timeout, echo_idx} !== '0)
      $display("FAIL async_reset: got ss=%b busy=%b done=%b ovr=%b tmo=%b idx=%0d want all 0",
               state_start, busy, scan_done, err_overrun, err_timeout, echo_idx);
    else passes++;
    dumpoff = 1'b0;
    @(negedge clk_sys);
    rst = 1'b0;
    step();
    checks++;
    if ({busy, echo_idx} !== '0) $display("FAIL post_reset: got busy=%b idx=%0d want 0 0", busy, echo_idx);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overrun();
    test_timeout();
    test_abort();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule
